// File: rtl/stream_scheduler_pkg.sv
// Shared constants for the producer-to-FIFO stream scheduler.
package stream_scheduler_pkg;

    localparam int unsigned SS_DATA_W  = 16;
    localparam int unsigned SS_QUOTA_W = 4;
    localparam int unsigned WCNT_W     = 16;
    localparam int unsigned ST_W       = 3;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_RUN   = 3'd1;
    localparam logic [ST_W-1:0] ST_WAIT  = 3'd2;
    localparam logic [ST_W-1:0] ST_SWAP  = 3'd3;
    localparam logic [ST_W-1:0] ST_DRAIN = 3'd4;

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_T    = 2'b01;
    localparam logic [1:0] SRC_F    = 2'b10;

    localparam logic [1:0] MODE_F    = 2'b00;
    localparam logic [1:0] MODE_T    = 2'b01;
    localparam logic [1:0] MODE_ALT  = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    // Display encoding of the internal source flag (1 = timer).
    function automatic logic [1:0] src_code(input logic src_is_t);
        return src_is_t ? SRC_T : SRC_F;
    endfunction

endpackage

// File: rtl/stream_scheduler_burst_counter.sv
// Per-burst word counter; flags the accept that reaches a nonzero quota.
module burst_counter #(
    parameter int unsigned QUOTA_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    input  logic [QUOTA_W-1:0] quota,
    output logic               burst_done_c
);

    logic [QUOTA_W-1:0] cnt_q;
    logic [QUOTA_W-1:0] cnt_inc;

    assign cnt_inc      = cnt_q + QUOTA_W'(1);
    // A zero quota means the burst never ends.
    assign burst_done_c = inc && (quota != '0) && (cnt_inc == quota);

    // Burst count register: clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_inc;
        end
    end

endmodule

// File: rtl/stream_scheduler.sv
// Arbitrates the Fibonacci and timer producers onto the single FIFO write port.
module stream_scheduler
    import stream_scheduler_pkg::*;
#(
    parameter int unsigned DATA_W  = SS_DATA_W,
    parameter int unsigned QUOTA_W = SS_QUOTA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [QUOTA_W-1:0] quota_f,
    input  logic [QUOTA_W-1:0] quota_t,
    input  logic               f_valid,
    input  logic [DATA_W-1:0]  f_data,
    input  logic               t_valid,
    input  logic [DATA_W-1:0]  t_data,
    input  logic               buffer_full,
    input  logic               buffer_empty,
    input  logic               rd_pending,
    output logic               f_en,
    output logic               t_en,
    output logic               wr_en,
    output logic [DATA_W-1:0]  wr_data,
    output logic [1:0]         active_src,
    output logic               busy,
    output logic [WCNT_W-1:0]  word_cnt,
    output logic               dropped
);

    logic [ST_W-1:0]    state_q, state_n;
    logic               src_q, src_n;      // 1 = timer, 0 = Fibonacci
    logic [1:0]         mode_q;
    logic [QUOTA_W-1:0] quota_f_q, quota_t_q;

    logic               src_valid;
    logic [DATA_W-1:0]  src_data;
    logic [QUOTA_W-1:0] quota_sel;
    logic [1:0]         mode_eff;
    logic               run_start;
    logic               accept;
    logic               burst_clr;
    logic               burst_done_c;
    logic               swap_req;
    logic               drop_set;
    logic               src_shown;

    assign src_valid = src_q ? t_valid : f_valid;
    assign src_data  = src_q ? t_data  : f_data;
    assign quota_sel = src_q ? quota_t_q : quota_f_q;
    assign mode_eff  = (mode == MODE_RSVD) ? MODE_F : mode;
    assign run_start = (state_q == ST_IDLE) && start && !stop;
    assign accept    = (state_q == ST_RUN) && src_valid && !buffer_full;
    assign burst_clr = run_start || (state_q == ST_SWAP);
    assign swap_req  = accept && burst_done_c && (mode_q == MODE_ALT);

    burst_counter #(
        .QUOTA_W (QUOTA_W)
    ) u_burst_counter (
        .clk          (clk),
        .rst          (rst),
        .clr          (burst_clr),
        .inc          (accept),
        .quota        (quota_sel),
        .burst_done_c (burst_done_c)
    );

    // State, source and run-configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            src_q     <= 1'b0;
            mode_q    <= MODE_F;
            quota_f_q <= '0;
            quota_t_q <= '0;
        end else begin
            state_q <= state_n;
            src_q   <= src_n;
            if (run_start) begin
                mode_q    <= mode_eff;
                quota_f_q <= quota_f;
                quota_t_q <= quota_t;
            end
        end
    end

    // Next-state logic; stop outranks full and quota in every active state.
    always_comb begin
        state_n  = state_q;
        src_n    = src_q;
        drop_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run_start) begin
                    state_n = ST_RUN;
                    src_n   = (mode_eff == MODE_T);
                end
            end
            ST_RUN: begin
                drop_set = src_valid && buffer_full;
                if (stop)             state_n = ST_DRAIN;
                else if (buffer_full) state_n = ST_WAIT;
                else if (swap_req)    state_n = ST_SWAP;
            end
            ST_WAIT: begin
                if (stop)              state_n = ST_DRAIN;
                else if (!buffer_full) state_n = ST_RUN;
            end
            ST_SWAP: begin
                if (stop) begin
                    state_n = ST_DRAIN;
                end else begin
                    state_n = ST_RUN;
                    src_n   = !src_q;
                end
            end
            ST_DRAIN: begin
                if (buffer_empty && !rd_pending) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign src_shown = (state_n == ST_RUN) || (state_n == ST_WAIT) || (state_n == ST_SWAP);

    // Registered outputs, decoded from the upcoming state so they track the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_en       <= 1'b0;
            t_en       <= 1'b0;
            busy       <= 1'b0;
            active_src <= SRC_NONE;
            wr_en      <= 1'b0;
            wr_data    <= '0;
            word_cnt   <= '0;
            dropped    <= 1'b0;
        end else begin
            f_en       <= (state_n == ST_RUN) && !src_n;
            t_en       <= (state_n == ST_RUN) && src_n;
            busy       <= (state_n != ST_IDLE);
            active_src <= src_shown ? src_code(src_n) : SRC_NONE;
            wr_en      <= accept;
            if (accept) wr_data <= src_data;
            if (run_start) begin
                word_cnt <= '0;
                dropped  <= 1'b0;
            end else begin
                if (accept)   word_cnt <= word_cnt + WCNT_W'(1);
                if (drop_set) dropped  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_scheduler.sv
// Randomized scoreboard bench for stream_scheduler against a cycle-level reference model.
module tb_stream_scheduler;

    logic        clk = 1'b0;
    logic        rst, start, stop;
    logic [1:0]  mode;
    logic [3:0]  quota_f, quota_t;
    logic        f_valid, t_valid;
    logic [15:0] f_data, t_data;
    logic        buffer_full, buffer_empty, rd_pending;
    logic        f_en, t_en, wr_en, busy, dropped;
    logic [15:0] wr_data, word_cnt;
    logic [1:0]  active_src;

    stream_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .quota_f(quota_f), .quota_t(quota_t),
        .f_valid(f_valid), .f_data(f_data), .t_valid(t_valid), .t_data(t_data),
        .buffer_full(buffer_full), .buffer_empty(buffer_empty), .rd_pending(rd_pending),
        .f_en(f_en), .t_en(t_en), .wr_en(wr_en), .wr_data(wr_data),
        .active_src(active_src), .busy(busy), .word_cnt(word_cnt), .dropped(dropped)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vecs = 0;
    int errs = 0;

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;
    exp_t exp_q[$];

    typedef enum int {M_IDLE, M_RUN, M_WAIT, M_SWAP, M_DRAIN} mphase_t;
    mphase_t     m = M_IDLE;
    bit          m_is_t;          // currently selected producer is the timer
    int          m_mode, m_qf, m_qt, m_burst, m_cnt;
    bit          m_drop;
    logic [15:0] m_wd;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: advances the scheduler's behaviour by one clock using the current inputs.
    task automatic model_step();
        bit          v;
        logic [15:0] d;
        int          q;
        exp_t        e;
        if (rst) begin
            m = M_IDLE; m_is_t = 0; m_cnt = 0; m_drop = 0; m_wd = 16'h0; m_burst = 0;
            return;
        end
        case (m)
            M_IDLE: if (start && !stop) begin
                m      = M_RUN;
                m_mode = (mode == 2'b11) ? 0 : int'(mode);
                m_is_t = (m_mode == 1);
                m_qf   = int'(quota_f);
                m_qt   = int'(quota_t);
                m_cnt  = 0; m_drop = 0; m_burst = 0;
            end
            M_RUN: begin
                v = m_is_t ? t_valid : f_valid;
                d = m_is_t ? t_data : f_data;
                q = m_is_t ? m_qt : m_qf;
                if (v && !buffer_full) begin
                    e.due = cyc + 1;
                    e.data = d;
                    exp_q.push_back(e);
                    m_wd = d;
                    m_cnt = (m_cnt + 1) % 65536;
                    m_burst++;
                end
                if (v && buffer_full) m_drop = 1;
                if (stop)             m = M_DRAIN;
                else if (buffer_full) m = M_WAIT;
                else if (v && m_mode == 2 && q != 0 && m_burst == q) m = M_SWAP;
            end
            M_WAIT: begin
                if (stop)              m = M_DRAIN;
                else if (!buffer_full) m = M_RUN;
            end
            M_SWAP: begin
                if (stop) m = M_DRAIN;
                else begin
                    m_is_t = !m_is_t;
                    m_burst = 0;
                    m = M_RUN;
                end
            end
            M_DRAIN: if (buffer_empty && !rd_pending) m = M_IDLE;
            default: m = M_IDLE;
        endcase
    endtask

    task automatic check_outputs();
        bit   shown;
        logic [1:0] act;
        shown = (m == M_RUN) || (m == M_WAIT) || (m == M_SWAP);
        act   = shown ? (m_is_t ? 2'b01 : 2'b10) : 2'b00;
        cmp("f_en",       32'(f_en),       32'(m == M_RUN && !m_is_t));
        cmp("t_en",       32'(t_en),       32'(m == M_RUN && m_is_t));
        cmp("busy",       32'(busy),       32'(m != M_IDLE));
        cmp("active_src", 32'(active_src), 32'(act));
        cmp("word_cnt",   32'(word_cnt),   32'(m_cnt));
        cmp("dropped",    32'(dropped),    32'(m_drop));
        cmp("wr_data",    32'(wr_data),    32'(m_wd));
    endtask

    task automatic step(input bit r, input bit s, input bit p, input bit fv, input bit tv,
                        input bit full, input bit emp, input bit rdp);
        rst = r; start = s; stop = p; f_valid = fv; t_valid = tv;
        buffer_full = full; buffer_empty = emp; rd_pending = rdp;
        f_data = 16'($urandom);
        t_data = 16'($urandom);
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic run_cfg(input logic [1:0] md, input logic [3:0] qf, input logic [3:0] qt);
        mode = md; quota_f = qf; quota_t = qt;
        step(0, 1, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic stop_and_drain();
        step(0, 0, 1, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected word, on time.
    always @(negedge clk) begin
        exp_t e;
        if (wr_en === 1'b1) begin
            vecs++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL wr_unexpected: got write %h, no write expected at cycle %0d", wr_data, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.due != cyc || e.data !== wr_data) begin
                    errs++;
                    $display("FAIL wr_word: got %h at cycle %0d expected %h at cycle %0d",
                             wr_data, cyc, e.data, e.due);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            vecs++;
            errs++;
            $display("FAIL wr_missing: got no write at cycle %0d expected %h", cyc, exp_q[0].data);
            void'(exp_q.pop_front());
        end
    end

    initial begin
        mode = 2'b00; quota_f = 4'd0; quota_t = 4'd0;
        step(1, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1, 0, 1, 0);

        // F only, five spaced words, timer strobes must be ignored
        run_cfg(2'b00, 4'd0, 4'd0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1, 1, 0, 1, 0);
            step(0, 0, 0, 0, 1, 0, 1, 0);
        end
        stop_and_drain();

        // Alternate F2/T3 with continuous valids
        run_cfg(2'b10, 4'd2, 4'd3);
        for (int i = 0; i < 14; i++) step(0, 0, 0, 1, 1, 0, 1, 0);
        stop_and_drain();

        // Full with valid: drop, wait, resume with retained burst count
        run_cfg(2'b10, 4'd4, 4'd1);
        step(0, 0, 0, 1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 0, 1, 0);
        stop_and_drain();

        // Stop together with an accepted timer word, then slow drain
        run_cfg(2'b01, 4'd0, 4'd0);
        step(0, 0, 0, 0, 1, 0, 1, 0);
        step(0, 0, 1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);

        // start and stop together in idle
        step(0, 1, 1, 1, 1, 0, 1, 0);
        step(0, 0, 0, 1, 1, 0, 1, 0);

        // Zero quota in alternate mode never swaps
        run_cfg(2'b10, 4'd0, 4'd5);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 1, 0, 1, 0);
        stop_and_drain();

        // Reset mid-run with a would-be accept, then a clean restart
        run_cfg(2'b11, 4'd0, 4'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0, 0, 1, 0);
        run_cfg(2'b00, 4'd0, 4'd0);
        step(0, 0, 0, 1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0, 1, 0);
        stop_and_drain();

        // Randomized runs; mode and quotas keep changing to exercise latching
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 100; i++) begin
                mode    = 2'($urandom);
                quota_f = 4'($urandom_range(0, 5));
                quota_t = 4'($urandom_range(0, 5));
                step($urandom_range(0, 199) == 0,
                     $urandom_range(0, 14) == 0,
                     $urandom_range(0, 24) == 0,
                     $urandom_range(0, 9) < 7,
                     $urandom_range(0, 9) < 7,
                     $urandom_range(0, 4) == 0,
                     $urandom_range(0, 9) < 6,
                     $urandom_range(0, 9) < 3);
            end
        end
        stop_and_drain();
        step(0, 0, 0, 0, 0, 0, 1, 0);

        @(negedge clk);
        @(negedge clk);
        vecs++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL wr_leftover: got %0d unwritten words expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
